// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM encodings and the default
// ack timeout.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY    = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

  localparam int ARB_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requester at or after
// the pointer, wrapping from CHANNELS-1 back to 0.
module mem_arbiter_rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IDXW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDXW-1:0]     ptr,
  output logic [CHANNELS-1:0] grant_onehot,
  output logic [IDXW-1:0]     grant_idx
);

  localparam logic [IDXW:0] CH_LIMIT = (IDXW + 1)'(CHANNELS);

  logic [2*CHANNELS-1:0] req_dbl_s;
  logic [CHANNELS-1:0]   req_rot_s;
  logic [IDXW:0]         offset_s;
  logic [IDXW:0]         sum_s;

  // Rotate so that the pointer position lands on bit 0.
  assign req_dbl_s = {req, req};
  assign req_rot_s = CHANNELS'(req_dbl_s >> ptr);

  // Lowest set bit of the rotated vector is the distance to the winner.
  always_comb begin
    offset_s = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      offset_s = req_rot_s[i] ? (IDXW + 1)'(i) : offset_s;
    end
  end

  // Map the distance back to an absolute channel index and one-hot grant.
  always_comb begin
    sum_s = {1'b0, ptr} + offset_s;
    if (sum_s >= CH_LIMIT) begin
      grant_idx = IDXW'(sum_s - CH_LIMIT);
    end else begin
      grant_idx = IDXW'(sum_s);
    end
    if (|req) begin
      grant_onehot = CHANNELS'(1'b1) << grant_idx;
    end else begin
      grant_onehot = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter in front of a single enable/rw/ack memory
// port. One transaction at a time; a hung memory is aborted after TIMEOUT
// busy cycles and reported through ch_error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int BYTES    = WIDTH / 8,
  parameter int TIMEOUT  = ARB_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       ch_enable,
  input  logic [CHANNELS-1:0]       ch_rw,
  input  logic [CHANNELS*32-1:0]    ch_addr,
  input  logic [CHANNELS*BYTES-1:0] ch_byte_enable,
  input  logic [CHANNELS*WIDTH-1:0] ch_data_in,
  output logic [WIDTH-1:0]          ch_data_out,
  output logic [CHANNELS-1:0]       ch_ack,
  output logic                      ch_error,
  output logic                      mem_enable,
  output logic                      mem_rw,
  output logic [31:0]               mem_addr,
  output logic [BYTES-1:0]          mem_byte_enable,
  output logic [WIDTH-1:0]          mem_data_in,
  input  logic [WIDTH-1:0]          mem_data_out,
  input  logic                      mem_ack
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(CHANNELS - 1);

  logic [1:0]          state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     grant_idx_q, grant_idx_d;
  logic [CHANNELS-1:0] grant_oh_q, grant_oh_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0] ch_ack_q, ch_ack_d;
  logic                ch_error_q, ch_error_d;
  logic [WIDTH-1:0]    ch_data_out_q, ch_data_out_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rw_q, mem_rw_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]    mem_byte_enable_q, mem_byte_enable_d;
  logic [WIDTH-1:0]    mem_data_in_q, mem_data_in_d;

  logic [CHANNELS-1:0] pick_oh_s;
  logic [IDXW-1:0]     pick_idx_s;
  logic [IDXW-1:0]     ptr_next_s;

  mem_arbiter_rr_picker #(
    .CHANNELS (CHANNELS),
    .IDXW     (IDXW)
  ) u_picker (
    .req          (ch_enable),
    .ptr          (ptr_q),
    .grant_onehot (pick_oh_s),
    .grant_idx    (pick_idx_s)
  );

  // Pointer moves just past the channel that was served.
  assign ptr_next_s = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + IDXW'(1'b1);

  // Next-state and output computation for the IDLE/BUSY/RELEASE sequence.
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    grant_idx_d       = grant_idx_q;
    grant_oh_d        = grant_oh_q;
    cnt_d             = '0;
    ch_ack_d          = '0;
    ch_error_d        = 1'b0;
    ch_data_out_d     = ch_data_out_q;
    mem_enable_d      = mem_enable_q;
    mem_rw_d          = mem_rw_q;
    mem_addr_d        = mem_addr_q;
    mem_byte_enable_d = mem_byte_enable_q;
    mem_data_in_d     = mem_data_in_q;
    case (state_q)
      ARB_IDLE: begin
        if (|ch_enable) begin
          grant_idx_d       = pick_idx_s;
          grant_oh_d        = pick_oh_s;
          mem_enable_d      = 1'b1;
          mem_rw_d          = ch_rw[pick_idx_s];
          mem_addr_d        = ch_addr[32*pick_idx_s +: 32];
          mem_byte_enable_d = ch_byte_enable[BYTES*pick_idx_s +: BYTES];
          mem_data_in_d     = ch_data_in[WIDTH*pick_idx_s +: WIDTH];
          state_d           = ARB_BUSY;
        end else begin
          mem_enable_d = 1'b0;
        end
      end
      ARB_BUSY: begin
        // A real ack always beats a timeout landing in the same cycle.
        if (mem_ack) begin
          ch_data_out_d = mem_data_out;
          ch_ack_d      = grant_oh_q;
          mem_enable_d  = 1'b0;
          ptr_d         = ptr_next_s;
          state_d       = ARB_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          ch_data_out_d = '0;
          ch_ack_d      = grant_oh_q;
          ch_error_d    = 1'b1;
          mem_enable_d  = 1'b0;
          ptr_d         = ptr_next_s;
          state_d       = ARB_RELEASE;
        end else begin
          cnt_d = cnt_q + CNTW'(1'b1);
        end
      end
      ARB_RELEASE: begin
        // One idle cycle with enable low lets the memory drop its ack.
        mem_enable_d = 1'b0;
        state_d      = ARB_IDLE;
      end
      default: begin
        mem_enable_d = 1'b0;
        state_d      = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ARB_IDLE;
      ptr_q             <= '0;
      grant_idx_q       <= '0;
      grant_oh_q        <= '0;
      cnt_q             <= '0;
      ch_ack_q          <= '0;
      ch_error_q        <= 1'b0;
      ch_data_out_q     <= '0;
      mem_enable_q      <= 1'b0;
      mem_rw_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_byte_enable_q <= '0;
      mem_data_in_q     <= '0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      grant_idx_q       <= grant_idx_d;
      grant_oh_q        <= grant_oh_d;
      cnt_q             <= cnt_d;
      ch_ack_q          <= ch_ack_d;
      ch_error_q        <= ch_error_d;
      ch_data_out_q     <= ch_data_out_d;
      mem_enable_q      <= mem_enable_d;
      mem_rw_q          <= mem_rw_d;
      mem_addr_q        <= mem_addr_d;
      mem_byte_enable_q <= mem_byte_enable_d;
      mem_data_in_q     <= mem_data_in_d;
    end
  end

  assign ch_ack          = ch_ack_q;
  assign ch_error        = ch_error_q;
  assign ch_data_out     = ch_data_out_q;
  assign mem_enable      = mem_enable_q;
  assign mem_rw          = mem_rw_q;
  assign mem_addr        = mem_addr_q;
  assign mem_byte_enable = mem_byte_enable_q;
  assign mem_data_in     = mem_data_in_q;

endmodule
